// File: rtl/if_id_pipe_buf_pkg.sv
// Shared constants for the IF->ID pipeline stage: reset polarity, NOP encoding,
// and the occupancy state encodings (the state value doubles as the entry count).
package if_id_pipe_buf_pkg;
  localparam logic        RstEnable    = 1'b1;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_ENC = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;
endpackage

// File: rtl/if_id_pipe_buf_slot.sv
// One IF/ID entry register (valid + pc + instr); clear beats load, and clearing
// returns the fields to RESET_PC / NOP_INST so an empty slot looks like a bubble.
module if_id_slot
  import if_id_pipe_buf_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_ENC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [INST_W-1:0] instr_in,
  output logic              vld,
  output logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] instr
);
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] instr_q, instr_d;

  always_comb begin
    vld_d   = vld_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      vld_d   = 1'b0;
      pc_d    = RESET_PC;
      instr_d = NOP_INST;
    end else if (load) begin
      vld_d   = 1'b1;
      pc_d    = pc_in;
      instr_d = instr_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      vld_q   <= 1'b0;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INST;
    end else begin
      vld_q   <= vld_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign vld   = vld_q;
  assign pc    = pc_q;
  assign instr = instr_q;
endmodule

// File: rtl/if_id_pipe_buf.sv
// IF->ID pipeline stage with valid/ready, stall and flush; 1-cycle latency.
// IF_ID_SKID_EN: 2-entry skid buffer with registered if_ready; otherwise 1 entry, combinational if_ready.
module if_id_pipe_buf
  import if_id_pipe_buf_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_ENC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_instr,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic              stall,
  input  logic              flush,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_instr,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [1:0]        occ
);
  logic [1:0]        state_q, state_d;
  logic              in_fire, out_fire;
  logic              main_load, main_clr;
  logic [ADDR_W-1:0] main_pc_in, main_pc;
  logic [INST_W-1:0] main_instr_in, main_instr;
  logic              main_vld;

  assign in_fire  = if_valid & if_ready;
  assign out_fire = main_vld & id_ready & ~stall;

`ifdef IF_ID_SKID_EN
  logic              skid_load, skid_clr, skid_vld;
  logic [ADDR_W-1:0] skid_pc;
  logic [INST_W-1:0] skid_instr;
  logic              main_from_skid;
  logic              if_ready_q, if_ready_d;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) begin
          main_load = 1'b1;
          state_d   = ST_FULL;
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = ST_SKID;
          end else if (out_fire) begin
            main_clr = 1'b1;
            state_d  = ST_EMPTY;
          end
        end
        ST_SKID: if (out_fire) begin
          // Skid is always younger than main, so it moves up rather than bypassing.
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clr       = 1'b1;
          state_d        = ST_FULL;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    if_ready_d = (state_d != ST_SKID);
  end

  assign main_pc_in    = main_from_skid ? skid_pc    : if_pc;
  assign main_instr_in = main_from_skid ? skid_instr : if_instr;

  if_id_slot #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(RESET_PC), .NOP_INST(NOP_INST)
  ) u_skid (
    .clk(clk), .rst(rst), .load(skid_load), .clear(skid_clr),
    .pc_in(if_pc), .instr_in(if_instr),
    .vld(skid_vld), .pc(skid_pc), .instr(skid_instr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) if_ready_q <= 1'b1;
    else                  if_ready_q <= if_ready_d;
  end

  assign if_ready = if_ready_q;
  assign occ      = {skid_vld, main_vld & ~skid_vld};
`else
  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_clr  = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) begin
          main_load = 1'b1;
          state_d   = ST_FULL;
        end
        ST_FULL: begin
          if (in_fire) begin
            main_load = 1'b1;
          end else if (out_fire) begin
            main_clr = 1'b1;
            state_d  = ST_EMPTY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_pc_in    = if_pc;
  assign main_instr_in = if_instr;
  assign if_ready      = ~main_vld | (id_ready & ~stall);
  assign occ           = state_q;
`endif

  if_id_slot #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(RESET_PC), .NOP_INST(NOP_INST)
  ) u_main (
    .clk(clk), .rst(rst), .load(main_load), .clear(main_clr),
    .pc_in(main_pc_in), .instr_in(main_instr_in),
    .vld(main_vld), .pc(main_pc), .instr(main_instr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) state_q <= ST_EMPTY;
    else                  state_q <= state_d;
  end

  assign id_valid = main_vld;
  assign id_pc    = main_pc;
  assign id_instr = main_vld ? main_instr : NOP_INST;
endmodule

// File: tb/tb_if_id_pipe_buf.sv
// Bench for if_id_pipe_buf: directed scenarios then random traffic against a queue model.
// Works with or without IF_ID_SKID_EN (model capacity follows the macro).
module tb_if_id_pipe_buf;
  localparam logic [31:0] RST_PC = 32'hDEAD_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef IF_ID_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc, if_instr, id_pc, id_instr;
  logic        if_valid, if_ready, stall, flush, id_valid, id_ready;
  logic [1:0]  occ;

  if_id_pipe_buf #(.ADDR_W(32), .INST_W(32), .RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
    .if_ready(if_ready), .stall(stall), .flush(flush), .id_pc(id_pc), .id_instr(id_instr),
    .id_valid(id_valid), .id_ready(id_ready), .occ(occ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t q[$];
  bit   pc_known_reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check the stage against the model, advance the model at the edge.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic rdy,
                     input logic st, input logic fl, output logic acc);
    logic exp_rdy, inf, outf;
    ent_t e;
    if_valid = v; if_pc = pc; if_instr = $urandom; id_ready = rdy; stall = st; flush = fl;
    #1;
    exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || (rdy && !st));
    check("if_ready", 32'(if_ready), 32'(exp_rdy));
    check("id_valid", 32'(id_valid), 32'(q.size() != 0));
    check("occ", 32'(occ), 32'(q.size()));
    if (q.size() != 0) begin
      check("id_pc", id_pc, q[0].pc);
      check("id_instr", id_instr, q[0].instr);
    end else begin
      check("id_instr_nop", id_instr, NOP);
      if (pc_known_reset) check("id_pc_reset", id_pc, RST_PC);
    end
    inf  = v & exp_rdy;
    outf = (q.size() != 0) & rdy & ~st;
    e.pc = pc; e.instr = if_instr;
    acc  = inf & ~fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
      pc_known_reset = 1'b1;
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) begin
        q.push_back(e);
        pc_known_reset = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  logic        acc;
  int          idx;
  logic [31:0] pcnt;

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_instr = '0;
    id_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    #1;
    check("rst_id_valid", 32'(id_valid), 32'(0));
    check("rst_occ", 32'(occ), 32'(0));
    check("rst_id_pc", id_pc, RST_PC);
    check("rst_id_instr", id_instr, NOP);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Streaming
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0, acc);
    for (int i = 0; i < 2; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

    // Back-pressure: id_ready low for 3 cycles, each PC re-offered until taken
    idx = 0;
    for (int c = 0; c < 16 && idx < 3; c++) begin
      cyc(1'b1, 32'h10 + 32'(idx * 4), c >= 3, 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    check("bp_all_accepted", 32'(idx), 32'(3));
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

    // Stall with id_ready high
    cyc(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, acc);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, acc);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, acc);
    cyc(1'b1, 32'h44, 1'b1, 1'b0, 1'b0, acc);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

    // Flush while holding entries, then flush with an accepted beat, then 0x80 first valid
    cyc(1'b1, 32'h60, 1'b0, 1'b0, 1'b0, acc);
    cyc(1'b1, 32'h64, 1'b0, 1'b0, 1'b0, acc);
    cyc(1'b1, 32'h68, 1'b0, 1'b0, 1'b1, acc);
    cyc(1'b1, 32'h70, 1'b1, 1'b0, 1'b1, acc);
    cyc(1'b1, 32'h80, 1'b1, 1'b0, 1'b0, acc);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

    // Asynchronous reset between edges
    cyc(1'b1, 32'h90, 1'b1, 1'b0, 1'b0, acc);
    cyc(1'b1, 32'h94, 1'b0, 1'b0, 1'b0, acc);
    #2 rst = 1'b1;
    #1;
    check("arst_id_valid", 32'(id_valid), 32'(0));
    check("arst_occ", 32'(occ), 32'(0));
    check("arst_id_pc", id_pc, RST_PC);
    check("arst_id_instr", id_instr, NOP);
    q.delete();
    pc_known_reset = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 32'hA0, 1'b1, 1'b0, 1'b0, acc);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

    // Random traffic
    pcnt = 32'h1000;
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom % 4) != 0, pcnt, ($urandom % 3) != 0, ($urandom % 6) == 0,
          ($urandom % 15) == 0, acc);
      if (acc) pcnt = pcnt + 32'd4;
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
